// File: rtl/led_strip_sequencer_if.sv
// Frame-buffer / encoder bus of the WS2812 frame sequencer.
// slave = sequencer side, master = the frame-buffer + host side.
interface led_strip_sequencer_if #(
    parameter int IW = 6
);
    logic          start;
    logic          continuous;
    logic          abort;
    logic [IW-1:0] pix_addr;
    logic [23:0]   pix_data;
    logic [1:0]    enc_sym;
    logic          bit_tick;
    logic          busy;
    logic          done;

    modport master (
        output start, continuous, abort, pix_data,
        input  pix_addr, enc_sym, bit_tick, busy, done
    );
    modport slave (
        input  start, continuous, abort, pix_data,
        output pix_addr, enc_sym, bit_tick, busy, done
    );
endinterface

// File: rtl/led_strip_sequencer.sv
// WS2812 frame sequencer: streams NUM_LEDS GRB words MSB first, one symbol per
// BIT_CYCLES clocks, prefetching the next pixel, then holds latch for RESET_CYCLES.
module led_strip_sequencer #(
    parameter int NUM_LEDS     = 60,
    parameter int BIT_CYCLES   = 61,
    parameter int RESET_CYCLES = 3000
) (
    input logic                  clk,
    input logic                  rst_n,
    led_strip_sequencer_if.slave bus
);
    localparam int IW   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int CMAX = (BIT_CYCLES > RESET_CYCLES) ? BIT_CYCLES : RESET_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [IW-1:0] PIX_LAST = IW'(NUM_LEDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND, S_LATCH} state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cyc;
    logic [4:0]    r_bit_idx;
    logic [IW-1:0] r_pix, r_addr;
    logic [23:0]   r_cur, r_next;
    logic [1:0]    r_pf;
    logic          r_tick, r_done;
    logic          w_cyc_wrap, w_bit_end, w_pf_issue;

    assign w_cyc_wrap = (r_cyc == BIT_LAST);
    assign w_bit_end  = w_cyc_wrap && (r_bit_idx == 5'd0);
    // Next pixel is requested in the first cycle of its predecessor's MSB.
    assign w_pf_issue = (r_state == S_SEND) && (r_cyc == '0) && (r_bit_idx == 5'd23) &&
                        (r_pix != PIX_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_FETCH;
            S_FETCH: begin
                if (bus.abort)               w_state_nxt = S_LATCH;
                else if (r_cyc == CW'(1))    w_state_nxt = S_SEND;
            end
            S_SEND: begin
                if (bus.abort || (w_bit_end && r_pix == PIX_LAST)) w_state_nxt = S_LATCH;
            end
            S_LATCH: begin
                if (r_cyc == RST_LAST) w_state_nxt = bus.continuous ? S_FETCH : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc     <= '0;
            r_bit_idx <= '0;
            r_pix     <= '0;
            r_addr    <= '0;
            r_cur     <= '0;
            r_next    <= '0;
            r_pf      <= '0;
            r_tick    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_done <= 1'b0;
            r_pf   <= {r_pf[0], w_pf_issue};
            if (r_pf[1]) r_next <= bus.pix_data;
            if (w_pf_issue) r_addr <= r_pix + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_state_nxt == S_FETCH) begin
                        r_addr <= '0;
                        r_cyc  <= '0;
                    end
                end
                S_FETCH: begin
                    r_cyc <= r_cyc + 1'b1;
                    if (w_state_nxt == S_SEND) begin
                        r_cur     <= bus.pix_data;
                        r_bit_idx <= 5'd23;
                        r_pix     <= '0;
                        r_cyc     <= '0;
                        r_tick    <= 1'b1;
                    end else if (w_state_nxt == S_LATCH) begin
                        r_cyc <= '0;
                    end
                end
                S_SEND: begin
                    if (w_state_nxt == S_LATCH) begin
                        r_cyc <= '0;
                    end else if (w_cyc_wrap) begin
                        r_cyc  <= '0;
                        r_tick <= 1'b1;
                        if (r_bit_idx == 5'd0) begin
                            r_bit_idx <= 5'd23;
                            r_pix     <= r_pix + 1'b1;
                            r_cur     <= r_next;
                        end else begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                        end
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                S_LATCH: begin
                    if (r_cyc == RST_LAST) begin
                        r_done <= 1'b1;
                        r_cyc  <= '0;
                        if (w_state_nxt == S_FETCH) r_addr <= '0;
                    end else begin
                        r_cyc <= r_cyc + 1'b1;
                    end
                end
                default: r_cyc <= '0;
            endcase
        end
    end

    assign bus.pix_addr = r_addr;
    assign bus.enc_sym  = (r_state == S_SEND) ? {1'b0, r_cur[r_bit_idx]} : 2'b11;
    assign bus.bit_tick = r_tick;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = r_done;
endmodule

// File: tb/tb_led_strip_sequencer.sv
// Bench for led_strip_sequencer: table of frames checked cycle by cycle against a
// bit-stream model, plus hand sequences for continuous, held start, tiny config and reset.
module tb_led_strip_sequencer;
    localparam int N   = 3,  BC  = 61, RC  = 3000, IW  = 2;
    localparam int N2  = 1,  BC2 = 4,  RC2 = 5,    IW2 = 1;
    localparam int SEND_LEN  = N * 24 * BC;
    localparam int FRAME_LEN = 2 + SEND_LEN + RC;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    led_strip_sequencer_if #(.IW(IW))  bus ();
    led_strip_sequencer_if #(.IW(IW2)) bus2 ();

    led_strip_sequencer #(.NUM_LEDS(N), .BIT_CYCLES(BC), .RESET_CYCLES(RC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave));
    led_strip_sequencer #(.NUM_LEDS(N2), .BIT_CYCLES(BC2), .RESET_CYCLES(RC2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    logic [23:0] ram [4];
    logic [23:0] ram2;
    always @(posedge clk) bus.pix_data  <= ram[bus.pix_addr];
    always @(posedge clk) bus2.pix_data <= ram2;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Model: after the start edge, 2 fetch cycles, then pixel p / bit b occupies
    // cycles 2 + (p*24 + 23-b)*BC .. +BC-1; latch follows; done at exp_len.
    task automatic expect_frame(input string tag, input int c0, input int abort_at,
                                input int abort_len, input int exp_len,
                                input int exp_ticks, input bit busy_at_done);
        logic [23:0] w [N];
        int sym_err = 0, tick_err = 0, busy_err = 0, addr_err = 0, done_err = 0, ticks = 0;
        int k, pix, exp_addr;
        logic [1:0] es;
        bit et, aborted;
        for (int i = 0; i < N; i++) w[i] = ram[i];
        for (int c = c0; c <= exp_len; c++) begin
            @(negedge clk);
            if (abort_at >= 0) bus.abort = (c >= abort_at) && (c < abort_at + abort_len);
            aborted = (abort_at >= 0) && (c > abort_at);
            k = c - 2;
            es = 2'b11; et = 1'b0; exp_addr = -1;
            if (c < 2) exp_addr = 0;
            if (!aborted && k >= 0 && k < SEND_LEN) begin
                pix = k / (24 * BC);
                es  = {1'b0, w[pix][23 - (k / BC) % 24]};
                et  = (k % BC == 0);
                exp_addr = (k % (24 * BC) == 0) ? pix : ((pix + 1 < N) ? pix + 1 : N - 1);
            end
            if (bus.enc_sym !== es) sym_err++;
            if (bus.bit_tick !== et) tick_err++;
            if (bus.done !== (c == exp_len)) done_err++;
            if (bus.busy !== ((c < exp_len) ? 1'b1 : busy_at_done)) busy_err++;
            if (exp_addr >= 0 && int'(bus.pix_addr) != exp_addr) addr_err++;
            ticks += int'(bus.bit_tick);
        end
        bus.abort = 1'b0;
        chk({tag, " symbol mismatches"}, sym_err, 0);
        chk({tag, " tick mismatches"}, tick_err, 0);
        chk({tag, " done mismatches"}, done_err, 0);
        chk({tag, " busy mismatches"}, busy_err, 0);
        chk({tag, " pix_addr mismatches"}, addr_err, 0);
        chk({tag, " tick count"}, ticks, exp_ticks);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    typedef struct {
        logic [2:0][23:0] w;
        int abort_at;
        int abort_len;
        int exp_len;
        int exp_ticks;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int ab_c, err, ticks, dn;
        logic [1:0] es;
        bus.start = 0; bus.continuous = 0; bus.abort = 0;
        bus2.start = 0; bus2.continuous = 0; bus2.abort = 0;
        for (int i = 0; i < 4; i++) ram[i] = '0;
        ram2 = '0;

        // abort sampled at the end of pixel 1, bit 10, 6th cycle
        ab_c = 2 + 1 * 24 * BC + (23 - 10) * BC + 5;
        tbl[0] = '{w: {24'h800001, 24'h00AA55, 24'hFF0000}, abort_at: -1, abort_len: 0,
                   exp_len: 7394, exp_ticks: 72};
        tbl[1] = '{w: {24'($urandom), 24'($urandom), 24'($urandom)}, abort_at: -1,
                   abort_len: 0, exp_len: FRAME_LEN, exp_ticks: 72};
        tbl[2] = '{w: {24'($urandom), 24'($urandom), 24'($urandom)}, abort_at: ab_c,
                   abort_len: 1, exp_len: ab_c + 3001, exp_ticks: 38};
        // abort in the first fetch cycle, held on into LATCH where it must be ignored
        tbl[3] = '{w: {24'($urandom), 24'($urandom), 24'($urandom)}, abort_at: 0,
                   abort_len: 10, exp_len: 3001, exp_ticks: 0};

        #5;
        chk("reset enc_sym", bus.enc_sym, 3);
        chk("reset busy", bus.busy, 0);
        chk("reset pix_addr", bus.pix_addr, 0);
        chk("reset bit_tick", bus.bit_tick, 0);
        chk("reset done", bus.done, 0);
        @(negedge clk) rst_n = 1'b1;

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) ram[i] = tbl[r].w[i];
            pulse_start();
            expect_frame($sformatf("vec%0d", r), 0, tbl[r].abort_at, tbl[r].abort_len,
                         tbl[r].exp_len, tbl[r].exp_ticks, 1'b0);
        end

        // back-to-back frames; RAM rewritten during the done cycle
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        bus.continuous = 1'b1;
        pulse_start();
        expect_frame("cont1", 0, -1, 0, FRAME_LEN, 72, 1'b1);
        for (int i = 0; i < N; i++) ram[i] = ~ram[i];
        bus.continuous = 1'b0;
        expect_frame("cont2", 1, -1, 0, FRAME_LEN, 72, 1'b0);

        // start held through a frame restarts one cycle after done
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        @(negedge clk) bus.start = 1'b1;
        @(posedge clk);
        expect_frame("hold1", 0, -1, 0, FRAME_LEN, 72, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        expect_frame("hold2", 0, -1, 0, FRAME_LEN, 72, 1'b0);

        // single-LED, short timing instance
        ram2 = 24'($urandom);
        @(negedge clk) bus2.start = 1'b1;
        @(posedge clk);
        #1 bus2.start = 1'b0;
        err = 0; ticks = 0; dn = -1;
        for (int c = 0; c <= 2 + 24 * BC2 + RC2 + 2; c++) begin
            @(negedge clk);
            es = 2'b11;
            if (c >= 2 && c < 2 + 24 * BC2) es = {1'b0, ram2[23 - (c - 2) / BC2]};
            if (bus2.enc_sym !== es || bus2.pix_addr !== 1'b0) err++;
            ticks += int'(bus2.bit_tick);
            if (bus2.done === 1'b1 && dn < 0) dn = c;
        end
        chk("small symbol/addr mismatches", err, 0);
        chk("small tick count", ticks, 24);
        chk("small done cycle", dn, 103);
        chk("small idle after", bus2.busy, 0);

        // start beats abort in IDLE, then async reset mid-SEND
        for (int i = 0; i < N; i++) ram[i] = 24'($urandom);
        @(negedge clk);
        bus.start = 1'b1; bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0; bus.abort = 1'b0;
        @(negedge clk);
        chk("start over abort busy", bus.busy, 1);
        repeat (2) @(negedge clk);
        chk("first bit tick", bus.bit_tick, 1);
        chk("first bit symbol", bus.enc_sym, {1'b0, ram[0][23]});
        repeat (100) @(negedge clk);
        chk("mid-send symbol", bus.enc_sym, {1'b0, ram[0][23 - 102 / BC]});
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async reset enc_sym", bus.enc_sym, 3);
        chk("async reset busy", bus.busy, 0);
        chk("async reset pix_addr", bus.pix_addr, 0);
        @(negedge clk) rst_n = 1'b1;
        bus.abort = 1'b1;
        err = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 5) bus.abort = 1'b0;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.enc_sym !== 2'b11) err++;
        end
        chk("post-reset idle, no done", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
